instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
Registered RV32I decode stage with a parametrised output queue. It accepts raw instruction words with their PC over a valid/ready handshake. Each word is classified by opcode into an instruction type, its register and funct fields are extracted, and its sign-extended immediate is built. The decoded records are buffered in a DEPTH-entry FIFO for the register-read/execute stage, so fetch and execute can stall independently.

Parameters:
WORD_SIZE, 32, instruction/immediate width; only 32 is legal (elaboration-time check).
PC_WIDTH, 32, width of the PC carried alongside each instruction.
DEPTH, 2, decoded-record FIFO entries; legal range 1..16.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
flush  input  1  synchronous; discards all queued records.
in_valid  input  1  in_instr/in_pc are valid.
in_ready  output  1  stage can accept this cycle.
in_instr  input  WORD_SIZE  raw instruction word.
in_pc  input  PC_WIDTH  PC of in_instr.
out_valid  output  1  head record is valid.
out_ready  input  1  consumer takes the head record.
out_pc  output  PC_WIDTH  PC of the head record.
out_instr_type  output  3  R=000, I=001, S=010, U=011, B=100, J=101, ILLEGAL=111.
out_opcode  output  7  instr[6:0].
out_rd  output  5  instr[11:7].
out_rs1  output  5  instr[19:15].
out_rs2  output  5  instr[24:20].
out_funct3  output  3  instr[14:12].
out_funct7  output  7  instr[31:25].
out_imm  output  WORD_SIZE  sign-extended immediate.
out_illegal  output  1  head opcode is not a recognised RV32I base opcode.
occupancy  output  $clog2(DEPTH+1)  number of queued records.

Behaviour:
- Reset, and flush with reset low:
  - empty the FIFO and zero the pointers.
  - occupancy=0, out_valid=0, out_illegal=0; every out_* data field reads 0.
  - Reset has priority over everything. Flush has priority over a push or pop in the same cycle.
- Handshake:
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = (occupancy != DEPTH). There is no combinational pass-through: when full with out_ready=1, in_ready stays 0 that cycle.
  - A simultaneous push and pop when not full leaves occupancy unchanged.
- Latency: a word accepted at edge N shows out_valid=1 with its decoded fields after edge N, provided it is at the head. There is no combinational in-to-out path.
- Output fields are driven from the head entry. They hold steady while out_valid && !out_ready.
- Type map by opcode:
  - 0110011 gives R.
  - 0010011, 1100111 and 0000011 give I.
  - 0100011 gives S.
  - 0110111 and 0010111 give U.
  - 1100011 gives B.
  - 1101111 gives J.
  - Any other opcode gives ILLEGAL (see optional feature).
- Immediates (instr abbreviated i; sign bit is i[31]):
  - I: sext(i[31:20]).
  - S: sext({i[31:25], i[11:7]}).
  - B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - U: {i[31:12], 12'b0}.
  - J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - R and ILLEGAL: 0.
- Decode is performed at push time and stored in the FIFO. Raw words are not stored.
- Pointers wrap modulo DEPTH, including non-power-of-2 DEPTH.

Optional Feature:
ILLEGAL_OPCODE_EN:
- Defined: unrecognised opcodes give type ILLEGAL (111) and out_illegal=1, with out_imm=0.
- Undefined: unrecognised opcodes default to type R (000) and out_illegal is tied to 0. This matches the legacy classifier.

Decomposition:
- Shared package decode_pkg holds:
  - INSTRUCTION_TYPE_* localparams, including ILLEGAL.
  - the opcode constants op, op_imm, jalr, load, store, branch, lui, auipc, jal.
  - a packed struct decoded_instr_t (pc, type, opcode, rd, rs1, rs2, funct3, funct7, imm, illegal).
- Sub-module imm_gen: a combinational word and type in, imm out. The FIFO is written inline in instr_decode_stage.

Test Plan:
1. Reset, then push 0xFFF10093 (addi x1,x2,-1), pc=0x100, out_ready=1 -> next cycle out_valid=1, type=001, rd=1, rs1=2, funct3=000, imm=0xFFFFFFFF, pc=0x100.
2. Push 0x00512423 (sw x5,8(x2)) then 0xFE000EE3 (beq x0,x0,-4) -> first record type=010, rs1=2, rs2=5, funct3=010, imm=8; second record type=100, imm=0xFFFFFFFC.
3. Push 0x123450B7 (lui) then 0x008000EF (jal x1,8) -> type 011, rd=1, imm=0x12345000; then type 101, rd=1, imm=8.
4. DEPTH=2, out_ready=0, in_valid held -> after 2 accepts occupancy=2 and in_ready=0. Raise out_ready with in_valid=1 -> that cycle pop only, next cycle in_ready=1. Records come out in order.
5. Push 0x00000000 -> with ILLEGAL_OPCODE_EN: type=111, out_illegal=1, imm=0. Without it: type=000, out_illegal=0.
6. Queue 2 records, then assert flush together with in_valid=1 -> next cycle occupancy=0, out_valid=0, flushed-cycle input dropped. Repeat with reset instead of flush -> same result.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: instruction-type codes, base opcodes and the decoded record.
// ILLEGAL_OPCODE_EN selects strict opcode classification in classify().
package decode_pkg;

    localparam int XLEN     = 32;
    localparam int DEC_PC_W = 64;

    localparam logic [2:0] INSTRUCTION_TYPE_R       = 3'b000;
    localparam logic [2:0] INSTRUCTION_TYPE_I       = 3'b001;
    localparam logic [2:0] INSTRUCTION_TYPE_S       = 3'b010;
    localparam logic [2:0] INSTRUCTION_TYPE_U       = 3'b011;
    localparam logic [2:0] INSTRUCTION_TYPE_B       = 3'b100;
    localparam logic [2:0] INSTRUCTION_TYPE_J       = 3'b101;
    localparam logic [2:0] INSTRUCTION_TYPE_ILLEGAL = 3'b111;

    localparam logic [6:0] op     = 7'b0110011;
    localparam logic [6:0] op_imm = 7'b0010011;
    localparam logic [6:0] jalr   = 7'b1100111;
    localparam logic [6:0] load   = 7'b0000011;
    localparam logic [6:0] store  = 7'b0100011;
    localparam logic [6:0] branch = 7'b1100011;
    localparam logic [6:0] lui    = 7'b0110111;
    localparam logic [6:0] auipc  = 7'b0010111;
    localparam logic [6:0] jal    = 7'b1101111;

    typedef struct packed {
        logic [DEC_PC_W-1:0] pc;
        logic [2:0]          instr_type;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [XLEN-1:0]     imm;
        logic                illegal;
    } decoded_instr_t;

    function automatic logic [2:0] classify(input logic [6:0] opc);
        logic [2:0] t;
        case (opc)
            op:                  t = INSTRUCTION_TYPE_R;
            op_imm, jalr, load:  t = INSTRUCTION_TYPE_I;
            store:               t = INSTRUCTION_TYPE_S;
            lui, auipc:          t = INSTRUCTION_TYPE_U;
            branch:              t = INSTRUCTION_TYPE_B;
            jal:                 t = INSTRUCTION_TYPE_J;
`ifdef ILLEGAL_OPCODE_EN
            default:             t = INSTRUCTION_TYPE_ILLEGAL;
`else
            // Legacy classifier: unknown opcodes fall through as R-type.
            default:             t = INSTRUCTION_TYPE_R;
`endif
        endcase
        return t;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate builder; R and ILLEGAL types produce zero.
module imm_gen
    import decode_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    input  logic [2:0]      instr_type,
    output logic [XLEN-1:0] imm
);

    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm = '0;
        case (instr_type)
            INSTRUCTION_TYPE_I: imm = {{20{instr[31]}}, instr[31:20]};
            INSTRUCTION_TYPE_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            INSTRUCTION_TYPE_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                       instr[11:8], 1'b0};
            INSTRUCTION_TYPE_U: imm = {instr[31:12], 12'b0};
            INSTRUCTION_TYPE_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                       instr[30:21], 1'b0};
            default:            imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32I decode stage: decodes on push, buffers records in a DEPTH-entry FIFO.
// Define ILLEGAL_OPCODE_EN to flag unrecognised opcodes as ILLEGAL instead of R-type.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int PC_WIDTH  = 32,
    parameter int DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_SIZE-1:0]       in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [2:0]                 out_instr_type,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [WORD_SIZE-1:0]       out_imm,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (WORD_SIZE != XLEN) begin : g_bad_word
            $error("instr_decode_stage: WORD_SIZE must be 32");
        end
        if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
            $error("instr_decode_stage: DEPTH must be in 1..16");
        end
        if (PC_WIDTH < 1 || PC_WIDTH > DEC_PC_W) begin : g_bad_pc
            $error("instr_decode_stage: PC_WIDTH out of range");
        end
    endgenerate

    logic [2:0]      in_type;
    logic [XLEN-1:0] in_imm;
    decoded_instr_t  in_rec;

    assign in_type = classify(in_instr[6:0]);

    imm_gen u_imm_gen (
        .instr      (in_instr),
        .instr_type (in_type),
        .imm        (in_imm)
    );

    always_comb begin
        in_rec            = '0;
        in_rec.pc         = DEC_PC_W'(in_pc);
        in_rec.instr_type = in_type;
        in_rec.opcode     = in_instr[6:0];
        in_rec.rd         = in_instr[11:7];
        in_rec.rs1        = in_instr[19:15];
        in_rec.rs2        = in_instr[24:20];
        in_rec.funct3     = in_instr[14:12];
        in_rec.funct7     = in_instr[31:25];
        in_rec.imm        = in_imm;
`ifdef ILLEGAL_OPCODE_EN
        in_rec.illegal    = (in_type == INSTRUCTION_TYPE_ILLEGAL);
`else
        in_rec.illegal    = 1'b0;
`endif
    end

    decoded_instr_t   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] count;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count != OCC_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) mem[wr_ptr] <= in_rec;
    end

    decoded_instr_t out_rec;
    logic           unused_pc;

    assign out_rec        = out_valid ? mem[rd_ptr] : '0;
    assign unused_pc      = ^out_rec.pc;
    assign out_pc         = out_rec.pc[PC_WIDTH-1:0];
    assign out_instr_type = out_rec.instr_type;
    assign out_opcode     = out_rec.opcode;
    assign out_rd         = out_rec.rd;
    assign out_rs1        = out_rec.rs1;
    assign out_rs2        = out_rec.rs2;
    assign out_funct3     = out_rec.funct3;
    assign out_funct7     = out_rec.funct7;
    assign out_imm        = out_rec.imm;
    assign out_illegal    = out_rec.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed plan scenarios plus randomized traffic against a queue model.
module tb_instr_decode_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [2:0]  out_instr_type, out_funct3;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [1:0]  occupancy;

    always #5 clk = ~clk;

    instr_decode_stage #(.WORD_SIZE(32), .PC_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr_type(out_instr_type), .out_opcode(out_opcode), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_imm(out_imm), .out_illegal(out_illegal),
        .occupancy(occupancy)
    );

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  ty;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } rec_t;

    rec_t mq[$];
    int   vec = 0;
    int   errs = 0;

    // Reference decode written from the ISA rules using signed integer arithmetic.
    function automatic rec_t model(input logic [31:0] w, input logic [31:0] pc);
        rec_t r;
        int   s;
        s     = $signed(w);
        r.pc  = pc;   r.op  = w[6:0];   r.rd = w[11:7];
        r.rs1 = w[19:15]; r.rs2 = w[24:20];
        r.f3  = w[14:12]; r.f7  = w[31:25];
        r.imm = '0;   r.ill = 1'b0;
        case (w[6:0])
            7'h33: r.ty = 3'd0;
            7'h13, 7'h67, 7'h03: begin r.ty = 3'd1; r.imm = s >>> 20; end
            7'h23: begin r.ty = 3'd2; r.imm = ((s >>> 25) << 5) | int'(w[11:7]); end
            7'h37, 7'h17: begin r.ty = 3'd3; r.imm = w & 32'hFFFF_F000; end
            7'h63: begin
                r.ty  = 3'd4;
                r.imm = ((s >>> 31) << 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5)
                        | (int'(w[11:8]) << 1);
            end
            7'h6F: begin
                r.ty  = 3'd5;
                r.imm = ((s >>> 31) << 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11)
                        | (int'(w[30:21]) << 1);
            end
`ifdef ILLEGAL_OPCODE_EN
            default: begin r.ty = 3'd7; r.ill = 1'b1; end
`else
            default: r.ty = 3'd0;
`endif
        endcase
        return r;
    endfunction

    function automatic logic [99:0] pk(input rec_t r);
        return {r.pc, r.ty, r.op, r.rd, r.rs1, r.rs2, r.f3, r.f7, r.imm, r.ill};
    endfunction

    function automatic logic [99:0] dut_pk();
        return {out_pc, out_instr_type, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
                out_funct7, out_imm, out_illegal};
    endfunction

    // Drive one cycle from a negedge, advance the model, return at the next negedge.
    task automatic step(input logic rst, input logic fl, input logic v,
                        input logic [31:0] w, input logic [31:0] pc, input logic rdy);
        bit pu, po;
        reset = rst; flush = fl; in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy;
        pu = v && (mq.size() < DEPTH);
        po = rdy && (mq.size() > 0);
        if (rst || fl) mq.delete();
        else begin
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(model(w, pc));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h0000_0013, 32'h40, 1);
        step(0, 0, 0, 0, 0, 0);
        vec++; if (occupancy !== 2'd0) begin errs++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", in_ready); end
        vec++; if (dut_pk() !== 100'd0) begin errs++; $display("FAIL reset_fields got %h want 0", dut_pk()); end
    endtask

    task automatic test_addi();
        step(0, 0, 1, 32'hFFF1_0093, 32'h100, 1);
        vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL addi_valid got %b want 1", out_valid); end
        vec++; if ({out_instr_type, out_rd, out_rs1, out_funct3} !== {3'b001, 5'd1, 5'd2, 3'b000})
            begin errs++; $display("FAIL addi_fields got %h want %h", {out_instr_type, out_rd, out_rs1, out_funct3}, {3'b001, 5'd1, 5'd2, 3'b000}); end
        vec++; if ({out_imm, out_pc} !== {32'hFFFF_FFFF, 32'h100})
            begin errs++; $display("FAIL addi_imm_pc got %h %h want ffffffff 100", out_imm, out_pc); end
        step(0, 0, 0, 0, 0, 1);
        vec++; if (occupancy !== 2'd0) begin errs++; $display("FAIL addi_drain got %0d want 0", occupancy); end
    endtask

    task automatic test_store_branch();
        step(0, 0, 1, 32'h0051_2423, 32'h200, 0);
        step(0, 0, 1, 32'hFE00_0EE3, 32'h204, 0);
        vec++; if ({out_instr_type, out_rs1, out_rs2, out_funct3, out_imm} !== {3'b010, 5'd2, 5'd5, 3'b010, 32'd8})
            begin errs++; $display("FAIL sw_fields got %h want %h", {out_instr_type, out_rs1, out_rs2, out_funct3, out_imm}, {3'b010, 5'd2, 5'd5, 3'b010, 32'd8}); end
        step(0, 0, 0, 0, 0, 1);
        vec++; if ({out_instr_type, out_imm} !== {3'b100, 32'hFFFF_FFFC})
            begin errs++; $display("FAIL beq_fields got %h %h want 4 fffffffc", out_instr_type, out_imm); end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_upper_jump();
        step(0, 0, 1, 32'h1234_50B7, 32'h300, 0);
        step(0, 0, 1, 32'h0080_00EF, 32'h304, 0);
        vec++; if ({out_instr_type, out_rd, out_imm} !== {3'b011, 5'd1, 32'h1234_5000})
            begin errs++; $display("FAIL lui_fields got %h want %h", {out_instr_type, out_rd, out_imm}, {3'b011, 5'd1, 32'h1234_5000}); end
        step(0, 0, 0, 0, 0, 1);
        vec++; if ({out_instr_type, out_rd, out_imm, out_pc} !== {3'b101, 5'd1, 32'd8, 32'h304})
            begin errs++; $display("FAIL jal_fields got %h want %h", {out_instr_type, out_rd, out_imm, out_pc}, {3'b101, 5'd1, 32'd8, 32'h304}); end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_full();
        step(0, 0, 1, 32'h0010_0093, 32'h400, 0);
        step(0, 0, 1, 32'h0020_0113, 32'h404, 0);
        vec++; if ({occupancy, in_ready} !== {2'd2, 1'b0})
            begin errs++; $display("FAIL full_state got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_ready); end
        step(0, 0, 1, 32'h0030_0193, 32'h408, 1);
        vec++; if ({occupancy, in_ready} !== {2'd1, 1'b1})
            begin errs++; $display("FAIL full_pop_only got occ=%0d rdy=%b want occ=1 rdy=1", occupancy, in_ready); end
        vec++; if ({out_pc, out_rd} !== {32'h404, 5'd2})
            begin errs++; $display("FAIL full_order got pc=%h rd=%0d want pc=404 rd=2", out_pc, out_rd); end
        step(0, 0, 0, 0, 0, 1);
        vec++; if (occupancy !== 2'd0) begin errs++; $display("FAIL full_drain got %0d want 0", occupancy); end
    endtask

    task automatic test_illegal();
        logic [2:0] ty_exp;
        logic       ill_exp;
`ifdef ILLEGAL_OPCODE_EN
        ty_exp = 3'b111; ill_exp = 1'b1;
`else
        ty_exp = 3'b000; ill_exp = 1'b0;
`endif
        step(0, 0, 1, 32'h0000_0000, 32'h500, 0);
        vec++; if ({out_instr_type, out_illegal, out_imm} !== {ty_exp, ill_exp, 32'd0})
            begin errs++; $display("FAIL illegal_fields got %h want %h", {out_instr_type, out_illegal, out_imm}, {ty_exp, ill_exp, 32'd0}); end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_flush_reset();
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 1, 32'h0051_2423, 32'h600, 0);
            step(0, 0, 1, 32'h1234_50B7, 32'h604, 0);
            vec++; if (occupancy !== 2'd2) begin errs++; $display("FAIL clr%0d_fill got %0d want 2", k, occupancy); end
            step(k == 1, k == 0, 1, 32'h0080_00EF, 32'h608, 1);
            vec++; if ({occupancy, out_valid} !== {2'd0, 1'b0})
                begin errs++; $display("FAIL clr%0d_empty got occ=%0d vld=%b want 0 0", k, occupancy, out_valid); end
            vec++; if (dut_pk() !== 100'd0) begin errs++; $display("FAIL clr%0d_fields got %h want 0", k, dut_pk()); end
            step(0, 0, 0, 0, 0, 0);
            vec++; if (occupancy !== 2'd0) begin errs++; $display("FAIL clr%0d_dropped got %0d want 0", k, occupancy); end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h7F};
        logic [31:0] w;
        for (int n = 0; n < 500; n++) begin
            w = $urandom;
            if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 9)];
            step(0, ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0), w, $urandom,
                 ($urandom_range(0, 2) != 0));
            vec++; if ({occupancy, out_valid, in_ready} !== {2'(mq.size()), mq.size() > 0, mq.size() != DEPTH})
                begin errs++; $display("FAIL rnd_state got occ=%0d vld=%b rdy=%b want occ=%0d", occupancy, out_valid, in_ready, mq.size()); end
            if (mq.size() > 0) begin
                vec++; if (dut_pk() !== pk(mq[0]))
                    begin errs++; $display("FAIL rnd_head got %h want %h", dut_pk(), pk(mq[0])); end
            end else begin
                vec++; if (dut_pk() !== 100'd0)
                    begin errs++; $display("FAIL rnd_empty got %h want 0", dut_pk()); end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_addi();
        test_store_branch();
        test_upper_jump();
        test_full();
        test_illegal();
        test_flush_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
